id_operand_fetch: RTL
=====================

Name: id_operand_fetch

Overview:
- Consumer end of the writeback interface: receives the register-file write port (write enable, destination address, data) from the WB pipeline register and holds the architectural register array.
- Sits in ID. Reads rs1/rs2 and resolves RAW hazards by forwarding from the EX, ME and WB bypass sources.
- Raises a stall request on load-use hazards.
- Registers the resolved operands into the ID/EX operand register.

Parameters:
- DATA_WIDTH, 32, width of registers and data buses
- REG_FILE_ADDR_WIDTH, 5, register address width
- NUM_REGS, 32, number of architectural registers (2**REG_FILE_ADDR_WIDTH)

Ports:
- clk  in  1  clock, rising edge
- _rst  in  1  reset, asynchronous, active-low
- reg_w_en_in  in  1  WB write enable
- rd_addr_in  in  REG_FILE_ADDR_WIDTH  WB destination register
- reg_data_in  in  DATA_WIDTH  WB write data
- id_valid  in  1  ID holds a valid instruction
- rs1_addr / rs2_addr  in  REG_FILE_ADDR_WIDTH  source register addresses
- rs1_used / rs2_used  in  1  instruction actually reads that source
- ex_reg_w_en, ex_rd_addr, ex_reg_data  in  1/ADDR/DATA  EX-stage bypass
- ex_is_load  in  1  EX instruction is a load (its data is not usable)
- me_reg_w_en, me_rd_addr, me_reg_data  in  1/ADDR/DATA  ME-stage bypass
- me_data_valid  in  1  ME data is final (load data returned)
- hold_in  in  1  downstream freeze of the ID/EX register
- flush_in  in  1  kill the ID/EX contents
- stall_req  out  1  combinational request to freeze IF/ID
- op_valid  out  1  ID/EX operand register valid
- rs1_data_out / rs2_data_out  out  DATA_WIDTH  registered operands

Behaviour:
- Reset (_rst low, asynchronous):
  - All array entries, rs1_data_out and rs2_data_out go to 0.
  - op_valid goes to 0.
  - Takes effect immediately, mid-operation included. No write is taken while _rst is low.
- Array write:
  - Happens on the rising edge when reg_w_en_in=1 and rd_addr_in!=0.
  - Writes to x0 are discarded; x0 always reads 0.
- Forwarded value per source (rsN, N=1,2), first match wins:
  - addr==0 -> 0
  - ex_reg_w_en && ex_rd_addr==addr -> ex_reg_data
  - me_reg_w_en && me_rd_addr==addr -> me_reg_data
  - reg_w_en_in && rd_addr_in==addr -> reg_data_in (write-through, same cycle)
  - otherwise -> array[addr]
- Hazard, per source:
  - haz_ex = rsN_used && addr!=0 && ex_reg_w_en && ex_is_load && ex_rd_addr==addr
  - haz_me = rsN_used && addr!=0 && me_reg_w_en && !me_data_valid && me_rd_addr==addr, and no EX match on addr.
  - stall_req = id_valid && (any haz for rs1 or rs2). It is purely combinational with no added latency.
- ID/EX register update at the rising edge, in priority order:
  1. flush_in -> op_valid=0, data=0. Flush beats hold and stall.
  2. hold_in -> all outputs unchanged.
  3. stall_req -> op_valid=0 (bubble inserted), data unchanged.
  4. Otherwise -> op_valid=id_valid; rs1_data_out/rs2_data_out = forwarded values.
- Latency: one cycle from ID inputs to the registered operands.
- A WB write and an ID read of the same register in the same cycle must return the new data.
- Unused sources (rsN_used=0) never cause a stall. Their forwarded value is still computed and captured.
- A WB write proceeds regardless of hold_in, flush_in or stall_req.
- Widths: all comparisons are full REG_FILE_ADDR_WIDTH equality. No arithmetic.

Test Plan:
- Reset: drive _rst low mid-cycle -> op_valid=0 and operands 0 immediately, before any clock edge. After release, reading x5 -> 0.
- Write-through: reg_w_en_in=1, rd=5, data=0xDEADBEEF, same cycle rs1=5 -> next cycle rs1_data_out=0xDEADBEEF. A later read of x5 with no bypass active -> 0xDEADBEEF.
- x0: write 0x1234 to x0, and EX bypass rd=0 data 0xFFFF -> rs1=0 reads 0, no stall.
- Priority: x7 is written 0x3 in WB, ME and EX hold x7 with 0x2 and 0x1 -> operand 0x1. Drop EX -> 0x2. Drop ME -> 0x3.
- Load-use: ex_is_load=1, ex_rd=9, rs2=9, rs2_used=1, id_valid=1 -> stall_req=1 and next op_valid=0. With rs2_used=0 -> no stall. ME load to x9 with me_data_valid=0 -> stall; me_data_valid=1 -> forwards me_reg_data.
- Control: hold_in=1 -> outputs frozen across 3 cycles. flush_in=1 together with hold_in=1 -> op_valid=0, data 0.

Source files
------------

// File: rtl/id_operand_fetch_if.sv
// rtl/id_operand_fetch_if.sv - writeback, bypass, ID-source and ID/EX operand signals of id_operand_fetch
interface id_operand_fetch_if #(
  parameter int DATA_WIDTH          = 32,
  parameter int REG_FILE_ADDR_WIDTH = 5
);
  logic                           reg_w_en_in;
  logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr_in;
  logic [DATA_WIDTH-1:0]          reg_data_in;

  logic                           id_valid;
  logic [REG_FILE_ADDR_WIDTH-1:0] rs1_addr;
  logic [REG_FILE_ADDR_WIDTH-1:0] rs2_addr;
  logic                           rs1_used;
  logic                           rs2_used;

  logic                           ex_reg_w_en;
  logic [REG_FILE_ADDR_WIDTH-1:0] ex_rd_addr;
  logic [DATA_WIDTH-1:0]          ex_reg_data;
  logic                           ex_is_load;

  logic                           me_reg_w_en;
  logic [REG_FILE_ADDR_WIDTH-1:0] me_rd_addr;
  logic [DATA_WIDTH-1:0]          me_reg_data;
  logic                           me_data_valid;

  logic                           hold_in;
  logic                           flush_in;

  logic                           stall_req;
  logic                           op_valid;
  logic [DATA_WIDTH-1:0]          rs1_data_out;
  logic [DATA_WIDTH-1:0]          rs2_data_out;

  modport master (
    output reg_w_en_in, rd_addr_in, reg_data_in,
    output id_valid, rs1_addr, rs2_addr, rs1_used, rs2_used,
    output ex_reg_w_en, ex_rd_addr, ex_reg_data, ex_is_load,
    output me_reg_w_en, me_rd_addr, me_reg_data, me_data_valid,
    output hold_in, flush_in,
    input  stall_req, op_valid, rs1_data_out, rs2_data_out
  );

  modport slave (
    input  reg_w_en_in, rd_addr_in, reg_data_in,
    input  id_valid, rs1_addr, rs2_addr, rs1_used, rs2_used,
    input  ex_reg_w_en, ex_rd_addr, ex_reg_data, ex_is_load,
    input  me_reg_w_en, me_rd_addr, me_reg_data, me_data_valid,
    input  hold_in, flush_in,
    output stall_req, op_valid, rs1_data_out, rs2_data_out
  );
endinterface

// File: rtl/id_operand_fetch.sv
// rtl/id_operand_fetch.sv - register file, EX/ME/WB operand bypass, load-use stall and ID/EX operand register
module id_operand_fetch #(
  parameter int DATA_WIDTH          = 32,
  parameter int REG_FILE_ADDR_WIDTH = 5,
  parameter int NUM_REGS            = 2 ** REG_FILE_ADDR_WIDTH
) (
  input logic               clk,
  input logic               _rst,
  id_operand_fetch_if.slave bus
);
  typedef logic [REG_FILE_ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0]          data_t;

  data_t regs [NUM_REGS];

  logic  ex_w, me_w, wb_w, ex_load, me_final;
  addr_t ex_rd, me_rd, wb_rd;
  data_t ex_d, me_d, wb_d;

  assign ex_w     = bus.ex_reg_w_en;
  assign ex_rd    = bus.ex_rd_addr;
  assign ex_d     = bus.ex_reg_data;
  assign ex_load  = bus.ex_is_load;
  assign me_w     = bus.me_reg_w_en;
  assign me_rd    = bus.me_rd_addr;
  assign me_d     = bus.me_reg_data;
  assign me_final = bus.me_data_valid;
  assign wb_w     = bus.reg_w_en_in;
  assign wb_rd    = bus.rd_addr_in;
  assign wb_d     = bus.reg_data_in;

  // Youngest producer wins; WB write-through covers the same-cycle array write.
  function automatic data_t fwd_value(input addr_t a);
    data_t v;
    if (a == '0)                   v = '0;
    else if (ex_w && ex_rd == a)   v = ex_d;
    else if (me_w && me_rd == a)   v = me_d;
    else if (wb_w && wb_rd == a)   v = wb_d;
    else                           v = regs[a];
    return v;
  endfunction

  // A younger EX match hides the ME producer, so only EX load state matters then.
  function automatic logic hazard(input addr_t a, input logic used);
    logic ex_match, haz_ex, haz_me;
    ex_match = ex_w && (ex_rd == a);
    haz_ex   = used && (a != '0) && ex_match && ex_load;
    haz_me   = used && (a != '0) && me_w && !me_final && (me_rd == a) && !ex_match;
    return haz_ex || haz_me;
  endfunction

  data_t rs1_fwd, rs2_fwd;
  logic  stall;

  always_comb begin
    rs1_fwd = fwd_value(bus.rs1_addr);
    rs2_fwd = fwd_value(bus.rs2_addr);
    stall   = bus.id_valid &&
              (hazard(bus.rs1_addr, bus.rs1_used) || hazard(bus.rs2_addr, bus.rs2_used));
  end

  assign bus.stall_req = stall;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      regs <= '{default: '0};
    end else if (wb_w && wb_rd != '0) begin
      regs[wb_rd] <= wb_d;
    end
  end

  logic  op_valid_q;
  data_t rs1_q, rs2_q;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      op_valid_q <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
    end else if (bus.flush_in) begin
      op_valid_q <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
    end else if (bus.hold_in) begin
      op_valid_q <= op_valid_q;
    end else if (stall) begin
      op_valid_q <= 1'b0;
    end else begin
      op_valid_q <= bus.id_valid;
      rs1_q      <= rs1_fwd;
      rs2_q      <= rs2_fwd;
    end
  end

  assign bus.op_valid     = op_valid_q;
  assign bus.rs1_data_out = rs1_q;
  assign bus.rs2_data_out = rs2_q;
endmodule
